// File: rtl/vencoder_pkg.sv
// Shared types and constants for the K=3 rate-1/2 convolutional frame encoder.
// VENC_PUNCTURE_EN selects rate-2/3 puncturing of the g0 bit on odd symbols.
package vencoder_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        DATA,
        TAIL,
        DRAIN,
        DONE
    } state_t;

    localparam logic [2:0] G1 = 3'b111;
    localparam logic [2:0] G0 = 3'b101;

    // {odd-index mask, even-index mask}
    localparam logic [3:0] PUNCT_PAT = 4'b10_11;

    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Convolutional encoder trellis: K-1 bit history plus generator XOR trees.
// Window is {b, s[0], s[1], ...} so generator MSB taps the incoming bit.
module conv_enc_core
    import vencoder_pkg::*;
#(
    parameter int K = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clr,
    input  logic       shift_en,
    input  logic       b,
    output logic [1:0] sym
);

    localparam logic [K-1:0] GA = K'(G1);
    localparam logic [K-1:0] GB = K'(G0);

    logic [K-2:0] s;
    logic [K-1:0] win;

    always_comb begin
        win = '0;
        win[K-1] = b;
        for (int i = 0; i < K-1; i++) begin
            win[K-2-i] = s[i];
        end
    end

    assign sym = {^(win & GA), ^(win & GB)};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s <= '0;
        end else if (clr) begin
            s <= '0;
        end else if (shift_en) begin
            s <= {s[K-3:0], b};
        end
    end

endmodule

// File: rtl/vencoder_frame_ctrl.sv
// Frame sequencer for the convolutional encoder: clear, paced payload, tail flush.
// Define VENC_PUNCTURE_EN to emit rate-2/3 puncturing masks on sym_mask.
module vencoder_frame_ctrl
    import vencoder_pkg::*;
#(
    parameter int FRAME_BITS     = 16,
    parameter int CONSTRAINT_LEN = 3,
    parameter int DIV            = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       in_valid,
    input  logic       in_bit,
    output logic       in_ready,
    output logic       sym_valid,
    output logic [1:0] sym,
    output logic [1:0] sym_mask,
    output logic       sym_first,
    output logic       sym_last,
    input  logic       sym_ready,
    output logic       busy,
    output logic       frame_done
);

    localparam int NSYM = FRAME_BITS + CONSTRAINT_LEN - 1;
    localparam int CW = cnt_width(FRAME_BITS + CONSTRAINT_LEN);
    localparam int DW = cnt_width(DIV);
    localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);
    localparam logic [CW-1:0] LAST_SYM = CW'(NSYM - 1);
    localparam logic [DW-1:0] DIV_TOP = DW'(DIV - 1);

    state_t state, state_nx;

    logic [DW-1:0] div_q;
    logic [CW-1:0] cnt_q;
    logic          stall;
    logic          slot;
    logic          tick;
    logic          accept;
    logic          load;
    logic          clr;
    logic          enc_b;
    logic [1:0]    enc_sym;

    // Pacing freezes whenever the output register is held by backpressure
    assign stall = sym_valid && !sym_ready;
    assign slot  = (div_q == DIV_TOP) && !stall;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = CLEAR;
            CLEAR:   state_nx = DATA;
            DATA:    if (accept && cnt_q == LAST_BIT) state_nx = TAIL;
            TAIL:    if (load && cnt_q == LAST_SYM) state_nx = DRAIN;
            DRAIN:   if (sym_valid && sym_ready && sym_last) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        tick       = 1'b0;
        in_ready   = 1'b0;
        accept     = 1'b0;
        load       = 1'b0;
        clr        = 1'b0;
        enc_b      = 1'b0;
        busy       = (state != IDLE);
        frame_done = (state == DONE);
        unique case (1'b1)
            (state == CLEAR): begin
                clr = 1'b1;
            end
            (state == DATA): begin
                tick     = slot;
                in_ready = slot;
                accept   = slot && in_valid;
                load     = slot && in_valid;
                enc_b    = in_bit;
            end
            (state == TAIL): begin
                tick = slot;
                load = slot;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
            cnt_q <= '0;
        end else if (clr) begin
            div_q <= '0;
            cnt_q <= '0;
        end else if ((state == DATA || state == TAIL) && !stall) begin
            div_q <= tick ? '0 : div_q + DW'(1);
            if (load) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    conv_enc_core #(
        .K(CONSTRAINT_LEN)
    ) u_core (
        .clock   (clock),
        .reset   (reset),
        .clr     (clr),
        .shift_en(load),
        .b       (enc_b),
        .sym     (enc_sym)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sym_valid <= 1'b0;
            sym       <= '0;
            sym_first <= 1'b0;
            sym_last  <= 1'b0;
        end else if (load) begin
            sym_valid <= 1'b1;
            sym       <= enc_sym;
            sym_first <= (cnt_q == '0);
            sym_last  <= (cnt_q == LAST_SYM);
        end else if (sym_ready) begin
            sym_valid <= 1'b0;
            sym_first <= 1'b0;
            sym_last  <= 1'b0;
        end
    end

`ifdef VENC_PUNCTURE_EN
    logic odd_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            odd_q    <= 1'b0;
            sym_mask <= 2'b11;
        end else if (clr) begin
            odd_q <= 1'b0;
        end else if (load) begin
            sym_mask <= odd_q ? PUNCT_PAT[3:2] : PUNCT_PAT[1:0];
            odd_q    <= !odd_q;
        end
    end
`else
    assign sym_mask = PUNCT_PAT[1:0];
`endif

endmodule

// File: tb/tb_vencoder_frame_ctrl.sv
// Bench for vencoder_frame_ctrl: directed frames plus random traffic
// against a bit-window convolution model.
module tb_vencoder_frame_ctrl;

    localparam int FB = 4;
    localparam int K = 3;
    localparam int DV = 2;
    localparam int NS = FB + K - 1;
    localparam int BASE = 3 + DV * NS;

    logic       clock;
    logic       reset;
    logic       start;
    logic       in_valid;
    logic       in_bit;
    logic       in_ready;
    logic       sym_valid;
    logic [1:0] sym;
    logic [1:0] sym_mask;
    logic       sym_first;
    logic       sym_last;
    logic       sym_ready;
    logic       busy;
    logic       frame_done;

    vencoder_frame_ctrl #(
        .FRAME_BITS    (FB),
        .CONSTRAINT_LEN(K),
        .DIV           (DV)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_bit    (in_bit),
        .in_ready  (in_ready),
        .sym_valid (sym_valid),
        .sym       (sym),
        .sym_mask  (sym_mask),
        .sym_first (sym_first),
        .sym_last  (sym_last),
        .sym_ready (sym_ready),
        .busy      (busy),
        .frame_done(frame_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int fails = 0;

    logic [1:0] q_sym[$];
    logic [1:0] q_mask[$];
    logic       q_first[$];
    logic       q_last[$];
    int cyc_done, cyc_last_hs, cyc_first_acc, cyc_first_valid;
    int n_done, n_slots, n_acc, n_ir_stall, n_hold_viol, n_stall;
    bit timed_out, end_busy;

    // Encoder output for symbol i: XOR taps over the last three input bits
    function automatic logic [1:0] model_sym(input logic [FB-1:0] bits,
                                             input int i);
        logic b0, b1, b2;
        b0 = (i < FB) ? bits[i] : 1'b0;
        b1 = (i >= 1 && i - 1 < FB) ? bits[i-1] : 1'b0;
        b2 = (i >= 2 && i - 2 < FB) ? bits[i-2] : 1'b0;
        return {b0 ^ b1 ^ b2, b0 ^ b2};
    endfunction

    function automatic logic [1:0] model_mask(input int i);
`ifdef VENC_PUNCTURE_EN
        return (i % 2 == 1) ? 2'b10 : 2'b11;
`else
        return (i >= 0) ? 2'b11 : 2'b11;
`endif
    endfunction

    // Drives one frame and records what the DUT does; tests judge the record
    task automatic run_frame(input logic [FB-1:0] bits, input int vmode,
                             input int rmode, input bit busy_start,
                             input bit rst_tail);
        logic hold_p, h_f, h_l;
        logic [1:0] h_sym, h_mask;
        bit stalled, fin;
        int tw;
        q_sym.delete();
        q_mask.delete();
        q_first.delete();
        q_last.delete();
        cyc_done = -1; cyc_last_hs = -1;
        cyc_first_acc = -1; cyc_first_valid = -1;
        n_done = 0; n_slots = 0; n_acc = 0;
        n_ir_stall = 0; n_hold_viol = 0; n_stall = 0;
        timed_out = 1; end_busy = 1;
        hold_p = 0; h_f = 0; h_l = 0; h_sym = 0; h_mask = 0;
        stalled = 0; fin = 0; tw = 0;
        @(negedge clock);
        start = 1; in_valid = 0; sym_ready = 1;
        for (int c = 0; c < 300 && !fin; c++) begin
            if (c > 0) begin
                @(negedge clock);
                start = busy_start && (c == 5);
                in_bit = (n_acc < FB) ? bits[n_acc] : 1'b0;
                case (vmode)
                    0: in_valid = 1;
                    1: in_valid = (n_slots != 1);
                    default: in_valid = ($urandom_range(0, 3) != 0);
                endcase
                stalled = (rmode == 1) && sym_valid &&
                          (q_sym.size() == 2) && (n_stall < 5);
                if (stalled) n_stall++;
                if (rmode == 2) sym_ready = ($urandom_range(0, 9) < 7);
                else sym_ready = !stalled;
            end
            #1;
            if (in_ready) begin
                n_slots++;
                if (stalled) n_ir_stall++;
                if (in_valid) begin
                    if (n_acc == 0) cyc_first_acc = c;
                    n_acc++;
                end
            end
            if (hold_p && (!sym_valid || sym !== h_sym ||
                sym_mask !== h_mask || sym_first !== h_f ||
                sym_last !== h_l)) n_hold_viol++;
            hold_p = sym_valid && !sym_ready;
            h_sym = sym; h_mask = sym_mask;
            h_f = sym_first; h_l = sym_last;
            if (sym_valid && cyc_first_valid < 0) cyc_first_valid = c;
            if (sym_valid && sym_ready) begin
                q_sym.push_back(sym);
                q_mask.push_back(sym_mask);
                q_first.push_back(sym_first);
                q_last.push_back(sym_last);
                cyc_last_hs = c;
            end
            if (frame_done) begin
                if (n_done == 0) cyc_done = c;
                n_done++;
            end
            if (n_done > 0 && c >= cyc_done + 3) begin
                timed_out = 0; end_busy = busy; fin = 1;
            end
            if (rst_tail && n_acc == FB) begin
                tw++;
                if (tw == 4) begin
                    reset = 0; timed_out = 0; fin = 1;
                end
            end
        end
        start = 0;
    endtask

    task automatic test_reset();
        checks++;
        if (busy !== 1'b0 || sym_valid !== 1'b0 || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_ctl: busy=%b vld=%b done=%b want 000",
                     busy, sym_valid, frame_done);
        end
        checks++;
        if (sym !== 2'b00 || sym_first !== 1'b0 || sym_last !== 1'b0) begin
            fails++;
            $display("FAIL reset_sym: sym=%b f=%b l=%b want 00 0 0",
                     sym, sym_first, sym_last);
        end
        checks++;
        if (sym_mask !== 2'b11 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL reset_mask: mask=%b rdy=%b want 11 0",
                     sym_mask, in_ready);
        end
        @(negedge clock);
        reset = 1;
        repeat (2) @(negedge clock);
        #1;
        checks++;
        if (busy !== 1'b0 || sym_valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: busy=%b vld=%b want 0 0",
                     busy, sym_valid);
        end
    endtask

    task automatic test_basic();
        logic [1:0] exp[NS] = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
        run_frame(4'b1101, 0, 0, 0, 0);
        checks++;
        if (timed_out) begin
            fails++; $display("FAIL basic_timeout: no frame_done");
        end
        checks++;
        if (q_sym.size() != NS) begin
            fails++;
            $display("FAIL basic_count: got %0d want %0d", q_sym.size(), NS);
        end
        for (int i = 0; i < NS && i < q_sym.size(); i++) begin
            checks++;
            if (q_sym[i] !== exp[i] || q_mask[i] !== model_mask(i) ||
                q_first[i] !== (i == 0) || q_last[i] !== (i == NS - 1)) begin
                fails++;
                $display("FAIL basic_sym%0d: got %b/%b/%b%b want %b/%b/%b%b",
                         i, q_sym[i], q_mask[i], q_first[i], q_last[i],
                         exp[i], model_mask(i), i == 0, i == NS - 1);
            end
        end
        checks++;
        if (cyc_first_valid - cyc_first_acc != 1) begin
            fails++;
            $display("FAIL basic_latency: got %0d want 1",
                     cyc_first_valid - cyc_first_acc);
        end
        checks++;
        if (cyc_done - cyc_last_hs != 1 || n_done != 1) begin
            fails++;
            $display("FAIL basic_done: gap %0d pulses %0d want 1 1",
                     cyc_done - cyc_last_hs, n_done);
        end
        checks++;
        if (cyc_done != BASE) begin
            fails++;
            $display("FAIL basic_len: got %0d want %0d", cyc_done, BASE);
        end
    endtask

    task automatic test_skip();
        run_frame(4'b1101, 1, 0, 0, 0);
        checks++;
        if (timed_out || n_slots != FB + 1 || n_acc != FB) begin
            fails++;
            $display("FAIL skip_slots: to=%0d slots=%0d acc=%0d want 0 %0d %0d",
                     timed_out, n_slots, n_acc, FB + 1, FB);
        end
        checks++;
        if (q_sym.size() != NS) begin
            fails++;
            $display("FAIL skip_count: got %0d want %0d", q_sym.size(), NS);
        end
        for (int i = 0; i < NS && i < q_sym.size(); i++) begin
            checks++;
            if (q_sym[i] !== model_sym(4'b1101, i)) begin
                fails++;
                $display("FAIL skip_sym%0d: got %b want %b",
                         i, q_sym[i], model_sym(4'b1101, i));
            end
        end
        checks++;
        if (cyc_done != BASE + DV) begin
            fails++;
            $display("FAIL skip_len: got %0d want %0d", cyc_done, BASE + DV);
        end
    endtask

    task automatic test_stall();
        run_frame(4'b1101, 0, 1, 0, 0);
        checks++;
        if (timed_out || n_hold_viol != 0 || n_ir_stall != 0) begin
            fails++;
            $display("FAIL stall_hold: to=%0d viol=%0d ir=%0d want 0 0 0",
                     timed_out, n_hold_viol, n_ir_stall);
        end
        checks++;
        if (q_sym.size() != NS) begin
            fails++;
            $display("FAIL stall_count: got %0d want %0d", q_sym.size(), NS);
        end
        for (int i = 0; i < NS && i < q_sym.size(); i++) begin
            checks++;
            if (q_sym[i] !== model_sym(4'b1101, i)) begin
                fails++;
                $display("FAIL stall_sym%0d: got %b want %b",
                         i, q_sym[i], model_sym(4'b1101, i));
            end
        end
        checks++;
        if (cyc_done != BASE + 5) begin
            fails++;
            $display("FAIL stall_len: got %0d want %0d", cyc_done, BASE + 5);
        end
    endtask

    task automatic test_reset_tail();
        int late_done;
        logic [1:0] exp[NS] = '{2'b11, 2'b01, 2'b10, 2'b10, 2'b01, 2'b11};
        run_frame(4'b1101, 0, 0, 0, 1);
        #1;
        checks++;
        if (timed_out || busy !== 1'b0 || sym_valid !== 1'b0) begin
            fails++;
            $display("FAIL rst_tail_now: to=%0d busy=%b vld=%b want 0 0 0",
                     timed_out, busy, sym_valid);
        end
        late_done = 0;
        repeat (3) begin
            @(negedge clock);
            #1;
            if (frame_done) late_done++;
        end
        reset = 1;
        repeat (3) begin
            @(negedge clock);
            #1;
            if (frame_done || busy) late_done++;
        end
        checks++;
        if (late_done != 0) begin
            fails++;
            $display("FAIL rst_tail_abandon: got %0d done/busy want 0",
                     late_done);
        end
        run_frame(4'b1111, 0, 0, 0, 0);
        checks++;
        if (timed_out || q_sym.size() != NS) begin
            fails++;
            $display("FAIL rst_new_count: to=%0d got %0d want %0d",
                     timed_out, q_sym.size(), NS);
        end
        for (int i = 0; i < NS && i < q_sym.size(); i++) begin
            checks++;
            if (q_sym[i] !== exp[i]) begin
                fails++;
                $display("FAIL rst_new_sym%0d: got %b want %b",
                         i, q_sym[i], exp[i]);
            end
        end
    endtask

    task automatic test_busy_start();
        run_frame(4'b0110, 0, 0, 1, 0);
        checks++;
        if (timed_out || q_sym.size() != NS || n_done != 1) begin
            fails++;
            $display("FAIL busy_start: to=%0d syms=%0d done=%0d want 0 %0d 1",
                     timed_out, q_sym.size(), n_done, NS);
        end
        checks++;
        if (end_busy !== 1'b0 || cyc_done != BASE) begin
            fails++;
            $display("FAIL busy_start_idle: busy=%b len=%0d want 0 %0d",
                     end_busy, cyc_done, BASE);
        end
    endtask

    task automatic test_random();
        logic [FB-1:0] bits;
        for (int f = 0; f < 6; f++) begin
            bits = FB'($urandom);
            run_frame(bits, 2, 2, 0, 0);
            checks++;
            if (timed_out || q_sym.size() != NS || n_done != 1) begin
                fails++;
                $display("FAIL rand%0d_count: to=%0d syms=%0d done=%0d",
                         f, timed_out, q_sym.size(), n_done);
            end
            checks++;
            if (n_hold_viol != 0 || cyc_done - cyc_last_hs != 1) begin
                fails++;
                $display("FAIL rand%0d_hold: viol=%0d gap=%0d want 0 1",
                         f, n_hold_viol, cyc_done - cyc_last_hs);
            end
            for (int i = 0; i < NS && i < q_sym.size(); i++) begin
                checks++;
                if (q_sym[i] !== model_sym(bits, i) ||
                    q_mask[i] !== model_mask(i) ||
                    q_first[i] !== (i == 0) ||
                    q_last[i] !== (i == NS - 1)) begin
                    fails++;
                    $display("FAIL rand%0d_sym%0d: got %b/%b/%b%b want %b/%b",
                             f, i, q_sym[i], q_mask[i], q_first[i],
                             q_last[i], model_sym(bits, i), model_mask(i));
                end
            end
        end
    endtask

    initial begin
        reset = 0;
        start = 0;
        in_valid = 0;
        in_bit = 0;
        sym_ready = 0;
        repeat (3) @(negedge clock);
        #1;
        test_reset();
        test_basic();
        test_skip();
        test_stall();
        test_reset_tail();
        test_busy_start();
        test_random();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule

// File: doc/vencoder_frame_ctrl.md
Name: vencoder_frame_ctrl

Overview:
Frame sequencer for the rate-1/2, K=3 convolutional encoder (generators g1=7, g0=5 octal). It takes a bit-serial payload over a valid/ready handshake and clears the encoder trellis at frame start. It paces encoder shifts with a clock-enable divider instead of a derived slow clock. It appends K-1 zero tail bits to flush the trellis and delivers coded symbol pairs over a valid/ready output with frame markers. It sits between the payload source and the PRML channel model.

Parameters:
FRAME_BITS, 16, payload bits per frame (>=1)
CONSTRAINT_LEN, 3, encoder constraint length K; tail length is K-1
DIV, 2, clock cycles per bit slot (>=1); replaces the divided slow clock

Ports:
clock  input  1  single system clock, rising edge
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle request to begin a frame; honoured only in IDLE
in_valid  input  1  payload bit available
in_bit  input  1  payload bit
in_ready  output  1  payload bit accepted this cycle when in_valid is also high
sym_valid  output  1  coded symbol pair valid
sym  output  2  {g1 bit, g0 bit}
sym_mask  output  2  per-bit validity of sym; see Optional Feature
sym_first  output  1  qualifies the first symbol of a frame
sym_last  output  1  qualifies the final tail symbol
sym_ready  input  1  downstream accepts the symbol
busy  output  1  high in any state except IDLE
frame_done  output  1  one-cycle pulse after the last symbol handshake

Behaviour:
- Reset (reset=0, async) forces state IDLE and clears the divider, bit counter, encoder shift register s[1:0] and sym register.
  - All outputs reset to 0, except sym_mask which resets to 2'b11.
  - Reset mid-frame abandons the frame; no frame_done is produced.
- FSM:
  - IDLE: start=1 -> CLEAR.
  - CLEAR: one cycle. Zeroes s, the divider and the bit counter -> DATA.
  - DATA: slot tick when divider == DIV-1 and the output register is free (sym_valid=0, or sym_ready=1 in the same cycle).
    - On a tick, in_ready=1 for that cycle only.
    - If in_valid=1: accept in_bit, load the symbol, increment the bit counter.
    - If in_valid=0: the slot is skipped, nothing shifts, and the divider restarts.
    - After the FRAME_BITS-th accept -> TAIL.
  - TAIL: on each tick, shift in 0 and emit a symbol. in_ready stays 0. After K-1 tail symbols are loaded -> DRAIN.
  - DRAIN: wait for the last symbol handshake -> DONE.
  - DONE: frame_done=1 for one cycle -> IDLE.
- Divider: counts only in DATA and TAIL. It freezes while sym_valid=1 and sym_ready=0 (backpressure stalls pacing). It wraps to 0 on a tick.
- Encoding, with b the bit shifted in and s[0] the most recent bit:
  - sym[1] = b ^ s[0] ^ s[1]
  - sym[0] = b ^ s[1]
  - then s <= {s[0], b}.
- Latency: sym_valid rises the cycle after the accepting tick. Symbol order equals bit order.
- Output: sym_valid holds, with sym and flags stable, until sym_ready=1.
- Symbols per frame: exactly FRAME_BITS + K-1.
- start is ignored whenever busy=1.

Optional Feature:
Macro: VENC_PUNCTURE_EN.
- Defined: rate-2/3 puncturing. The symbol index within the frame counts from 0. Odd-index symbols carry sym_mask=2'b10 (the g0 bit is punctured) and even-index symbols carry 2'b11. Symbol count and timing are unchanged.
- Undefined: sym_mask is constant 2'b11 and the index counter is not built.

Decomposition:
- Package vencoder_pkg holds:
  - state enum (IDLE, CLEAR, DATA, TAIL, DRAIN, DONE)
  - generator constants G1=3'b111 and G0=3'b101
  - puncture pattern constant
  - counter-width function clog2-based on FRAME_BITS + CONSTRAINT_LEN
- One sub-module, conv_enc_core: holds the K-1 bit shift register and generator XORs. It has shift-enable and synchronous-clear inputs and combinational sym from b and s. The FSM, divider and output register stay in the top.

Test Plan:
- FRAME_BITS=4, DIV=2, sym_ready=1, bits 1,0,1,1 with in_valid always 1 -> symbols 11,10,00,01,01,11; sym_first on the 1st, sym_last on the 6th; frame_done one cycle after the 6th handshake.
- Same frame with in_valid=0 at the 2nd slot -> one skipped slot (in_ready pulses with no accept), identical symbol sequence, 2 extra cycles.
- sym_ready held 0 for 5 cycles at the 3rd symbol -> sym=00 held stable, divider frozen, no in_ready pulse, no symbol lost or duplicated.
- Assert reset during TAIL, then run a new frame of 1,1,1,1 -> busy=0 immediately on reset; the new frame yields 11,01,10,10,01,11 (trellis cleared).
- start pulsed while busy -> ignored; exactly one frame of 6 symbols.
- With VENC_PUNCTURE_EN, first frame -> masks 11,10,11,10,11,10. Without the macro -> all 11.
